// File: rtl/fv_buf_pkg.sv
// Shared types and default sizing for the ping-pong feature-vector buffer array.
package fv_buf_pkg;

    localparam int FV_NUM_BANKS = 4;
    localparam int FV_WIDTH     = 128;
    localparam int FV_DEPTH     = 64;
    localparam int FV_ADDR_W    = $clog2(FV_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWAP
    } swap_state_e;

    typedef struct packed {
        logic                 valid;
        logic [FV_ADDR_W-1:0] addr;
    } fv_rd_req_t;

    typedef struct packed {
        logic                 valid;
        logic [FV_ADDR_W-1:0] addr;
        logic [FV_WIDTH-1:0]  data;
    } fv_wr_req_t;

endpackage

// File: rtl/fv_pingpong_bank.sv
// One FV bank: two single-port SRAM halves, read/write port steering, read pipeline
// and the saturating count of lines written since the last swap.
module fv_pingpong_bank #(
    parameter int FV_W   = 128,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd_sel,
    input  logic              i_single_buf,
    input  logic              i_lines_clr,
    input  logic              i_rd_fire,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_wr_fire,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [FV_W-1:0]   i_wr_data,
    output logic              o_rd_valid,
    output logic [FV_W-1:0]   o_rd_data,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_wr_lines
);
    import fv_buf_pkg::*;

    localparam int LINES_W = ADDR_W + 1;

    logic            w_wr_half;
    logic [1:0]      w_cen_n;
    logic [1:0]      w_wen_n;
    logic            r_rd_half;
    logic            r_v1;
    logic [FV_W-1:0] w_q;
    logic            w_valid_out;
    logic [FV_W-1:0] w_data_out;
    logic [LINES_W-1:0] r_wr_lines;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_wr_half = i_single_buf ? i_rd_sel : ~i_rd_sel;
        w_cen_n   = 2'b11;
        w_wen_n   = 2'b11;
        for (int h = 0; h < 2; h++) begin
            w_wen_n[h] = ~(i_wr_fire && (w_wr_half == 1'(h)));
            w_cen_n[h] = ~((i_rd_fire && (i_rd_sel == 1'(h))) || !w_wen_n[h]);
        end
    end

    for (genvar h = 0; h < 2; h++) begin : g_half
        logic [FV_W-1:0]   r_mem [DEPTH];
        logic [FV_W-1:0]   r_q;
        logic [ADDR_W-1:0] w_addr;

        assign w_addr = w_wen_n[h] ? i_rd_addr : i_wr_addr;

        // NOTE: SRAM arrays and their read latch are never reset; only control state is.
        always_ff @(posedge clk) begin
            if (!w_cen_n[h]) begin
                if (!w_wen_n[h]) r_mem[w_addr] <= i_wr_data;
                else             r_q           <= r_mem[w_addr];
            end
        end
    end

    assign w_q = r_rd_half ? g_half[1].r_q : g_half[0].r_q;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) r_v1 <= 1'b0;
        else       r_v1 <= i_rd_fire;
    end

    always_ff @(posedge clk) begin
        if (i_rd_fire) r_rd_half <= i_rd_sel;
    end

    if (RD_LAT == 2) begin : g_oreg
        logic            r_v2;
        logic [FV_W-1:0] r_data;

        always_ff @(posedge clk) begin
            if (reset) r_v2 <= 1'b0;
            else       r_v2 <= r_v1;
        end

        always_ff @(posedge clk) begin
            if (r_v1) r_data <= w_q;
        end

        assign w_valid_out = r_v2;
        assign w_data_out  = r_data;
        assign o_busy      = r_v1;
    end else begin : g_noreg
        assign w_valid_out = r_v1;
        assign w_data_out  = w_q;
        assign o_busy      = 1'b0;
    end

    assign o_rd_valid = w_valid_out & ~reset;
    assign o_rd_data  = o_rd_valid ? w_data_out : '0;

    always_ff @(posedge clk) begin
        if (reset || i_lines_clr)
            r_wr_lines <= '0;
        else if (i_wr_fire && (r_wr_lines != LINES_W'(DEPTH)))
            r_wr_lines <= r_wr_lines + LINES_W'(1);
    end

    assign o_wr_lines = r_wr_lines;

endmodule

// File: rtl/fv_pingpong_bank_array.sv
// Multi-bank ping-pong FV buffer: swap FSM that drains reads and flips the read half,
// plus one fv_pingpong_bank per bank.
module fv_pingpong_bank_array #(
    parameter int NUM_BANKS = fv_buf_pkg::FV_NUM_BANKS,
    parameter int FV_WIDTH  = fv_buf_pkg::FV_WIDTH,
    parameter int DEPTH     = fv_buf_pkg::FV_DEPTH,
    parameter int RD_LAT    = 2,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              single_buf,
    input  logic [NUM_BANKS-1:0]              rd_req_valid,
    input  logic [NUM_BANKS*ADDR_W-1:0]       rd_req_addr,
    output logic [NUM_BANKS-1:0]              rd_req_ready,
    output logic [NUM_BANKS-1:0]              rd_data_valid,
    output logic [NUM_BANKS*FV_WIDTH-1:0]     rd_data,
    input  logic [NUM_BANKS-1:0]              wr_valid,
    input  logic [NUM_BANKS*ADDR_W-1:0]       wr_addr,
    input  logic [NUM_BANKS*FV_WIDTH-1:0]     wr_data,
    output logic [NUM_BANKS-1:0]              wr_ready,
    input  logic                              swap_req,
    output logic                              swap_done,
    output logic                              rd_sel,
    output logic [NUM_BANKS*(ADDR_W+1)-1:0]   wr_lines
);
    import fv_buf_pkg::*;

    localparam int CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int LINES_W = ADDR_W + 1;

    swap_state_e          r_state;
    swap_state_e          w_state_next;
    logic [CNT_W-1:0]     r_drain_cnt;
    logic [CNT_W-1:0]     w_cnt_dec;
    logic                 r_rd_sel;
    logic                 r_single_buf;
    logic                 w_single_buf;
    logic                 w_rd_open;
    logic                 w_wr_open;
    logic                 w_lines_clr;
    logic [NUM_BANKS-1:0] w_busy;

    // Mode is live while IDLE and frozen for the duration of a swap sequence.
    assign w_single_buf = (r_state == IDLE) ? single_buf : r_single_buf;
    assign w_cnt_dec    = (r_drain_cnt == '0) ? '0 : r_drain_cnt - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_drain_cnt  <= '0;
            r_rd_sel     <= 1'b0;
            r_single_buf <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_single_buf <= w_single_buf;
            if (r_state == IDLE && swap_req) r_drain_cnt <= CNT_W'(RD_LAT - 1);
            else if (r_state == DRAIN)       r_drain_cnt <= w_cnt_dec;
            if (r_state == SWAP)             r_rd_sel    <= ~r_rd_sel;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (swap_req) w_state_next = DRAIN;
            DRAIN:   if (w_cnt_dec == '0 && ~|w_busy) w_state_next = SWAP;
            SWAP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_rd_open   = ~reset & (r_state == IDLE) & ~swap_req;
        w_wr_open   = ~reset & (r_state != SWAP);
        w_lines_clr = (r_state == SWAP);
        swap_done   = ~reset & (r_state == SWAP);
    end

    assign rd_sel = r_rd_sel;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic w_rd_fire;
        logic w_wr_fire;

        // In single-buffer mode both ports share one SRAM, so a same-bank write wins.
        assign rd_req_ready[b] = w_rd_open & ~(w_single_buf & wr_valid[b]);
        assign wr_ready[b]     = w_wr_open;
        assign w_rd_fire       = rd_req_valid[b] & rd_req_ready[b];
        assign w_wr_fire       = wr_valid[b] & wr_ready[b];

        fv_pingpong_bank #(
            .FV_W   (FV_WIDTH),
            .DEPTH  (DEPTH),
            .RD_LAT (RD_LAT),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk          (clk),
            .reset        (reset),
            .i_rd_sel     (r_rd_sel),
            .i_single_buf (w_single_buf),
            .i_lines_clr  (w_lines_clr),
            .i_rd_fire    (w_rd_fire),
            .i_rd_addr    (rd_req_addr[b*ADDR_W +: ADDR_W]),
            .i_wr_fire    (w_wr_fire),
            .i_wr_addr    (wr_addr[b*ADDR_W +: ADDR_W]),
            .i_wr_data    (wr_data[b*FV_WIDTH +: FV_WIDTH]),
            .o_rd_valid   (rd_data_valid[b]),
            .o_rd_data    (rd_data[b*FV_WIDTH +: FV_WIDTH]),
            .o_busy       (w_busy[b]),
            .o_wr_lines   (wr_lines[b*LINES_W +: LINES_W])
        );
    end

endmodule

// File: tb/tb_fv_pingpong_bank_array.sv
// Scoreboard bench: a behavioural model of both halves per bank predicts readiness, swap
// timing and read data; a negedge monitor pops expected reads when the DUT presents data.
module tb_fv_pingpong_bank_array;

    localparam int NB     = 4;
    localparam int W      = 128;
    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int RD_LAT = 2;
    localparam int LW     = AW + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              single_buf = 1'b0;
    logic [NB-1:0]     rd_req_valid = '0;
    logic [NB*AW-1:0]  rd_req_addr = '0;
    logic [NB-1:0]     rd_req_ready;
    logic [NB-1:0]     rd_data_valid;
    logic [NB*W-1:0]   rd_data;
    logic [NB-1:0]     wr_valid = '0;
    logic [NB*AW-1:0]  wr_addr = '0;
    logic [NB*W-1:0]   wr_data = '0;
    logic [NB-1:0]     wr_ready;
    logic              swap_req = 1'b0;
    logic              swap_done;
    logic              rd_sel;
    logic [NB*LW-1:0]  wr_lines;

    always #5 clk = ~clk;

    fv_pingpong_bank_array #(
        .NUM_BANKS (NB),
        .FV_WIDTH  (W),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .single_buf    (single_buf),
        .rd_req_valid  (rd_req_valid),
        .rd_req_addr   (rd_req_addr),
        .rd_req_ready  (rd_req_ready),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .swap_req      (swap_req),
        .swap_done     (swap_done),
        .rd_sel        (rd_sel),
        .wr_lines      (wr_lines)
    );

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t         exp_q [NB][$];
    logic [W-1:0] m_mem [NB][2][DEPTH];
    logic         m_rd_sel = 1'b0;
    int           m_phase = 0;   // cycles since an accepted swap request: 0 idle, 1 drain, 2 swap
    int           m_lines [NB];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    exp_t mon_e;
    logic mon_exp_v;
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            mon_exp_v = (exp_q[b].size() > 0) && (exp_q[b][0].due == cyc);
            check($sformatf("rd_data_valid[%0d]", b), W'(rd_data_valid[b]), W'(mon_exp_v));
            if (mon_exp_v) begin
                mon_e = exp_q[b].pop_front();
                if (rd_data_valid[b])
                    check($sformatf("rd_data[%0d]", b), rd_data[b*W +: W], mon_e.data);
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input logic [NB-1:0] rv, input logic [NB*AW-1:0] ra,
                        input logic [NB-1:0] wv, input logic [NB*AW-1:0] wa,
                        input logic [NB*W-1:0] wd, input logic sreq, input logic sb);
        logic [NB-1:0] e_rrdy;
        logic [NB-1:0] e_wrdy;
        logic [NB*LW-1:0] e_lines;
        logic e_done;
        logic wh;
        rd_req_valid = rv; rd_req_addr = ra;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        swap_req = sreq; single_buf = sb;
        @(negedge clk);
        for (int b = 0; b < NB; b++) begin
            e_rrdy[b] = (m_phase == 0) && !sreq && !(sb && wv[b]);
            e_wrdy[b] = (m_phase != 2);
            e_lines[b*LW +: LW] = LW'(m_lines[b]);
        end
        e_done = (m_phase == 2);
        check("rd_req_ready", W'(rd_req_ready), W'(e_rrdy));
        check("wr_ready", W'(wr_ready), W'(e_wrdy));
        check("swap_done", W'(swap_done), W'(e_done));
        check("rd_sel", W'(rd_sel), W'(m_rd_sel));
        check("wr_lines", W'(wr_lines), W'(e_lines));
        wh = sb ? m_rd_sel : !m_rd_sel;
        for (int b = 0; b < NB; b++) begin
            if (rv[b] && e_rrdy[b])
                exp_q[b].push_back('{data: m_mem[b][m_rd_sel][ra[b*AW +: AW]], due: cyc + RD_LAT});
            if (wv[b] && e_wrdy[b]) begin
                m_mem[b][wh][wa[b*AW +: AW]] = wd[b*W +: W];
                if (m_lines[b] < DEPTH) m_lines[b]++;
            end
        end
        case (m_phase)
            0: if (sreq) m_phase = 1;
            1: m_phase = 2;
            default: begin
                m_phase = 0;
                m_rd_sel = !m_rd_sel;
                for (int b = 0; b < NB; b++) m_lines[b] = 0;
            end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic sb);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, 1'b0, sb);
    endtask

    task automatic settle(input logic sb);
        while (m_phase != 0) step('0, '0, '0, '0, '0, 1'b0, sb);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        rd_req_valid = '0; wr_valid = '0; swap_req = 1'b0; single_buf = 1'b0;
        for (int b = 0; b < NB; b++) exp_q[b].delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("reset rd_req_ready", W'(rd_req_ready), '0);
            check("reset wr_ready", W'(wr_ready), '0);
            check("reset swap_done", W'(swap_done), '0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        m_phase = 0;
        m_rd_sel = 1'b0;
        for (int b = 0; b < NB; b++) m_lines[b] = 0;
    endtask

    function automatic logic [NB*AW-1:0] addr_all(input int a);
        logic [NB*AW-1:0] v;
        for (int b = 0; b < NB; b++) v[b*AW +: AW] = AW'(a);
        return v;
    endfunction

    task automatic rand_steps(input int n, input logic sb, input int swap_pct);
        logic [NB-1:0] rv, wv;
        logic [NB*AW-1:0] ra, wa;
        logic [NB*W-1:0] wd;
        for (int i = 0; i < n; i++) begin
            rv = NB'($urandom);
            wv = NB'($urandom);
            for (int b = 0; b < NB; b++) begin
                ra[b*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
                wa[b*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
                wd[b*W +: W]   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            step(rv, ra, wv, wa, wd, ($urandom_range(0, 99) < swap_pct), sb);
        end
    endtask

    logic [NB*W-1:0] wd;
    initial begin
        for (int b = 0; b < NB; b++) m_lines[b] = 0;
        do_reset(2);

        // Write pong while ping is read, swap, then read the line back from the new read half.
        wd = '0; wd[0 +: W] = W'('hA5);
        step(4'b0001, '0, 4'b0001, addr_all(5), wd, 1'b0, 1'b0);
        step('0, '0, '0, '0, '0, 1'b1, 1'b0);
        settle(1'b0);
        step(4'b0001, addr_all(5), '0, '0, '0, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Fill both halves of every bank so random reads always hit known data.
        for (int h = 0; h < 2; h++) begin
            for (int a = 0; a < DEPTH; a++) begin
                for (int b = 0; b < NB; b++) wd[b*W +: W] = {$urandom(), $urandom(), $urandom(), $urandom()};
                step('0, '0, '1, addr_all(a), wd, 1'b0, 1'b0);
            end
            step('0, '0, '0, '0, '0, 1'b1, 1'b0);
            settle(1'b0);
        end

        // Read accepted, then swap request while reads keep being offered.
        step('1, addr_all(7), '0, '0, '0, 1'b0, 1'b0);
        step('1, addr_all(8), '0, '0, '0, 1'b1, 1'b0);
        step('1, addr_all(9), '0, '0, '0, 1'b0, 1'b0);
        step('1, addr_all(10), '0, '0, '0, 1'b0, 1'b0);
        step('1, addr_all(11), '0, '0, '0, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Back-to-back reads on all banks with concurrent writes to the other half.
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < NB; b++) wd[b*W +: W] = {$urandom(), $urandom(), $urandom(), $urandom()};
            step('1, addr_all(i), '1, addr_all(i), wd, 1'b0, 1'b0);
        end
        rand_steps(150, 1'b0, 5);
        settle(1'b0);

        // Single-buffer mode: same-bank write wins, read retries and sees the new data.
        wd = '0; wd[2*W +: W] = W'('h77);
        step(4'b0100, addr_all(3), 4'b0100, addr_all(3), wd, 1'b0, 1'b1);
        step(4'b0100, addr_all(3), '0, '0, '0, 1'b0, 1'b1);
        idle(3, 1'b1);
        rand_steps(100, 1'b1, 5);
        settle(1'b1);

        // Saturation of the write-line counter, and a second request during DRAIN.
        for (int i = 0; i < 70; i++) begin
            for (int b = 0; b < NB; b++) wd[b*W +: W] = {$urandom(), $urandom(), $urandom(), $urandom()};
            step('0, '0, 4'b0010, addr_all(i % DEPTH), wd, 1'b0, 1'b0);
        end
        step('0, '0, '0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, '0, '0, 1'b1, 1'b0);
        step('0, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(3, 1'b0);

        // Reset during DRAIN with a read still in flight.
        if (!m_rd_sel) begin
            step('0, '0, '0, '0, '0, 1'b1, 1'b0);
            settle(1'b0);
        end
        step('1, addr_all(20), '0, '0, '0, 1'b0, 1'b0);
        step('0, '0, '0, '0, '0, 1'b1, 1'b0);
        do_reset(1);
        idle(4, 1'b0);
        rand_steps(60, 1'b0, 5);
        settle(1'b0);
        idle(4, 1'b0);

        for (int b = 0; b < NB; b++)
            check($sformatf("pending reads[%0d]", b), W'(exp_q[b].size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fv_pingpong_bank_array.md
Name: fv_pingpong_bank_array

Overview:
- Parametrised multi-bank feature-vector buffer. Each bank holds two SRAM halves (ping and pong).
- One half serves the read stream to the small-FV stage. The other half accepts replay/update write-back.
- A swap FSM drains in-flight reads and exchanges the roles of the two halves between iterations.
- A single-buffer mode makes both ports use one half, for configurations without replay.

Parameters:
- NUM_BANKS, 4, number of independent FV banks.
- FV_WIDTH, 128, bits per FV line.
- DEPTH, 64, lines per half-buffer (power of two, at least 2). ADDR_W = clog2(DEPTH) is derived.
- RD_LAT, 2, read latency in cycles from request accept to data valid (1 = SRAM only; 2 = SRAM plus output register).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- single_buf  in  1  1 = read and write both target half rd_sel; sample only while state is IDLE
- rd_req_valid  in  NUM_BANKS  per-bank read request
- rd_req_addr  in  NUM_BANKS*ADDR_W  per-bank read line address
- rd_req_ready  out  NUM_BANKS  read accept; combinational
- rd_data_valid  out  NUM_BANKS  read data valid
- rd_data  out  NUM_BANKS*FV_WIDTH  read data
- wr_valid  in  NUM_BANKS  per-bank write
- wr_addr  in  NUM_BANKS*ADDR_W  write line address
- wr_data  in  NUM_BANKS*FV_WIDTH  write data
- wr_ready  out  NUM_BANKS  write accept; combinational
- swap_req  in  1  single-cycle swap request
- swap_done  out  1  one-cycle pulse when the roles have been exchanged
- rd_sel  out  1  half currently on the read side (0 = ping)
- wr_lines  out  NUM_BANKS*(ADDR_W+1)  per-bank count of accepted writes since the last swap; saturates at DEPTH

Behaviour:
- Reset:
  - All outputs 0; wr_ready and rd_req_ready evaluate from state IDLE the next cycle.
  - rd_sel = 0, state = IDLE, drain counter = 0, wr_lines = 0, read pipeline valids cleared.
  - SRAM contents are not reset.
  - Reset mid-operation: in-flight reads are discarded, no rd_data_valid after reset, and no swap_done.
- Read path:
  - A request is accepted when rd_req_valid & rd_req_ready in cycle t.
  - rd_data_valid = 1 with data in cycle t+RD_LAT, exactly one cycle per accept.
  - Fully pipelined: one accept per bank per cycle.
  - Reads are served from half rd_sel.
- Write path:
  - Accepted when wr_valid & wr_ready.
  - Writes go to half ~rd_sel, or to half rd_sel when single_buf = 1. The SRAM update happens at the clock edge.
  - Each accepted write increments that bank's wr_lines (saturating).
- rd_req_ready[b] = (state == IDLE) & ~swap_req & ~(single_buf & wr_valid[b]).
  - In single_buf mode a same-bank write wins and the read stalls.
  - Dual mode has no conflict: the two halves are separate SRAMs.
- wr_ready[b] = (state != SWAP). Writes during DRAIN still land in the old write half.
- FSM:
  - IDLE: on swap_req, go to DRAIN and load the counter with RD_LAT-1. swap_req outside IDLE is ignored (no queuing).
  - DRAIN: decrement the counter each cycle. When it is 0 and no read valid is in the pipeline, go to SWAP. Reads are blocked throughout.
  - SWAP (one cycle): swap_done = 1, rd_sel toggles at the end of the cycle, all wr_lines clear, return to IDLE.
  - Timing with RD_LAT = 2: swap_req at t, DRAIN t+1, SWAP t+2, new rd_sel visible and reads open at t+3.
- single_buf = 1: the swap sequence still runs and rd_sel still toggles, so software can flip halves.
- Addresses are always in range by construction (DEPTH is a power of two). No wrap logic is needed beyond address width truncation.

Decomposition:
- Shared package fv_buf_pkg holds:
  - fv_rd_req_t {valid, addr}, fv_wr_req_t {valid, addr, data}
  - swap FSM state enum {IDLE, DRAIN, SWAP}
  - default constants FV_NUM_BANKS, FV_WIDTH, FV_DEPTH
- Sub-module fv_pingpong_bank: one bank containing two SRAM instances (active-low CEN/WEN macro, 1-cycle read), port muxing by rd_sel and single_buf, the optional output register when RD_LAT = 2, and the wr_lines counter.
- The top level holds the swap FSM and a generate loop over NUM_BANKS.

Test Plan:
- Reset, then write bank0 addr 5 = 0xA5 (pong), swap, read bank0 addr 5 → rd_data 0xA5 at t+2; rd_sel = 1; wr_lines[0] returns to 0 after SWAP.
- Read accepted at t, swap_req at t+1 → rd_req_ready = 0 for t+1..t+3; rd_data_valid at t+2; swap_done only at t+3; no data lost.
- All 4 banks issue back-to-back reads for 16 cycles with concurrent writes → 16 rd_data_valid per bank in order, with read data unaffected by writes to the other half.
- single_buf = 1, bank2 write addr 3 = 0x77 and read addr 3 in the same cycle → read stalls a cycle, then returns 0x77 two cycles after acceptance.
- Write 70 lines to bank1 with DEPTH = 64 → wr_lines[1] saturates at 64; swap_req while in DRAIN is ignored, giving exactly one swap_done.
- Assert reset during DRAIN → next cycle state IDLE, rd_sel = 0, rd_data_valid = 0, no swap_done pulse.
